// File: rtl/mem_stage_pkg.sv
// mem_stage shared definitions.
// State encoding, access-size codes and funct3 field helpers.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int F3_UNSIGNED = 2;

  // Sizes wider than the bus collapse to a full bus access.
  function automatic logic [1:0] size_clamp(
    input logic [1:0] sz,
    input logic [1:0] max_sz
  );
    return (sz > max_sz) ? max_sz : sz;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage load alignment.
// Moves the addressed lane to bit 0, truncates and extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int FUNCT3_WIDTH = 3,
  parameter int OFF_W        = $clog2(BUS_WIDTH / 8)
) (
  input  logic [BUS_WIDTH-1:0]    rdata,
  input  logic [OFF_W-1:0]        off,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  output logic [BUS_WIDTH-1:0]    data
);

  localparam int NBYTES = BUS_WIDTH / 8;
  localparam logic [1:0] MAX_SZ = 2'($clog2(NBYTES));

  logic [1:0]           sz;
  logic [BUS_WIDTH-1:0] shifted;
  logic [BUS_WIDTH-1:0] keep;
  logic                 sign;

  assign sz      = size_clamp(funct3[1:0], MAX_SZ);
  assign shifted = rdata >> {off, 3'b000};

  // Keep mask for the access size and the sign bit at its top.
  always_comb begin
    keep = '0;
    sign = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i < (1 << sz)) keep[i*8 +: 8] = 8'hFF;
      if (i == (1 << sz) - 1) sign = shifted[i*8+7];
    end
  end

  assign data = (shifted & keep)
              | ((sign & ~funct3[F3_UNSIGNED]) ? ~keep : '0);

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store pipeline stage.
// Single-outstanding request/ready data port with stall.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int FUNCT3_WIDTH = 3,
  parameter int STRB_WIDTH   = BUS_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  input  logic [BUS_WIDTH-1:0]    alu_fpu_result,
  input  logic [BUS_WIDTH-1:0]    write_data,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [BUS_WIDTH-1:0]    dmem_addr,
  output logic [BUS_WIDTH-1:0]    dmem_wdata,
  output logic [STRB_WIDTH-1:0]   dmem_wstrb,
  input  logic                    dmem_ready,
  input  logic [BUS_WIDTH-1:0]    dmem_rdata,
  output logic                    stall,
  output logic                    misaligned,
  output logic [BUS_WIDTH-1:0]    wb_data
);

  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam logic [1:0] MAX_SZ = 2'($clog2(STRB_WIDTH));

  state_t state_q;
  state_t state_d;

  logic [1:0]              sz;
  logic [OFF_W-1:0]        off;
  logic                    mem_op;
  logic                    low_bad;
  logic                    access;
  logic [STRB_WIDTH-1:0]   st_strb;
  logic [BUS_WIDTH-1:0]    st_keep;
  logic [BUS_WIDTH-1:0]    st_data;

  logic                    lat_read;
  logic [OFF_W-1:0]        lat_off;
  logic [FUNCT3_WIDTH-1:0] lat_f3;
  logic [BUS_WIDTH-1:0]    load_data;
  logic [BUS_WIDTH-1:0]    align_data;

  assign off    = alu_fpu_result[OFF_W-1:0];
  assign sz     = size_clamp(funct3[1:0], MAX_SZ);
  assign mem_op = valid_in & (mem_read | mem_write);

  // Address bits below the access size must be zero.
  always_comb begin
    unique case (sz)
      SZ_B:    low_bad = 1'b0;
      SZ_H:    low_bad = alu_fpu_result[0];
      SZ_W:    low_bad = |alu_fpu_result[1:0];
      default: low_bad = |alu_fpu_result[2:0];
    endcase
  end

  assign misaligned = mem_op & low_bad;
  assign access     = mem_op & ~low_bad;

  assign stall = ~rst
               & ((state_q == IDLE & access) | (state_q == BUSY));

  // Byte enables and data mask for the access size at lane 0.
  always_comb begin
    st_strb = '0;
    st_keep = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (i < (1 << sz)) begin
        st_strb[i]       = 1'b1;
        st_keep[i*8 +: 8] = 8'hFF;
      end
    end
  end

  assign st_data = (write_data & st_keep) << {off, 3'b000};

  mem_stage_load_align #(
    .BUS_WIDTH    (BUS_WIDTH),
    .FUNCT3_WIDTH (FUNCT3_WIDTH),
    .OFF_W        (OFF_W)
  ) u_load_align (
    .rdata  (dmem_rdata),
    .off    (lat_off),
    .funct3 (lat_f3),
    .data   (align_data)
  );

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (access) state_d = BUSY;
      BUSY:    if (dmem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request issue, hold, completion and load capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      lat_read   <= 1'b0;
      lat_off    <= '0;
      lat_f3     <= '0;
      load_data  <= '0;
    end else if (state_q == IDLE && access) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write;
      dmem_addr  <= {alu_fpu_result[BUS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      dmem_wdata <= st_data;
      dmem_wstrb <= st_strb << off;
      lat_read   <= mem_read;
      lat_off    <= off;
      lat_f3     <= funct3;
    end else if (state_q == BUSY && dmem_ready) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      load_data  <= align_data;
    end
  end

  assign wb_data = (state_q == DONE && lat_read) ? load_data
                                                 : alu_fpu_result;

endmodule

// File: tb/tb_mem_stage.sv
// mem_stage bench: directed cases plus random transactions
// checked against a size/offset arithmetic model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [63:0] alu_fpu_result;
  logic [63:0] write_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;
  logic        stall;
  logic        misaligned;
  logic [63:0] wb_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .funct3         (funct3),
    .alu_fpu_result (alu_fpu_result),
    .write_data     (write_data),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata),
    .stall          (stall),
    .misaligned     (misaligned),
    .wb_data        (wb_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] size_mask(input int nb);
    return (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF
                     : (64'd1 << (nb * 8)) - 64'd1;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rd,
                                           input logic [63:0] a,
                                           input logic [2:0] f3);
    int nb;
    logic [63:0] v, m;
    nb = 1 << f3[1:0];
    m  = size_mask(nb);
    v  = (rd >> (a[2:0] * 8)) & m;
    if (!f3[2] && v[nb*8-1]) v = v | ~m;
    return v;
  endfunction

  // One instruction from its IDLE cycle through DONE.
  task automatic run(input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] rdat,
                     input int nwait);
    int nb;
    bit mem, mis;
    logic [7:0]  strb;
    logic [63:0] lm, ewd;
    mem  = rd | wr;
    nb   = 1 << f3[1:0];
    mis  = mem && (a % nb != 0);
    strb = 8'(((1 << nb) - 1) << a[2:0]);
    lm   = '0;
    for (int i = 0; i < 8; i++) if (strb[i]) lm[i*8 +: 8] = 8'hFF;
    ewd  = (wd & size_mask(nb)) << (a[2:0] * 8);
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = rd; mem_write = wr;
    funct3 = f3; alu_fpu_result = a; write_data = wd;
    dmem_ready = 1'($urandom_range(0, 1));
    dmem_rdata = {$urandom, $urandom};
    #1;
    chk("misaligned", 64'(misaligned), 64'(mis));
    chk("stall_issue", 64'(stall), 64'(mem && !mis));
    chk("req_idle", 64'(dmem_req), 64'd0);
    if (!mem || mis) begin
      chk("wb_pass", wb_data, a);
      return;
    end
    for (int k = 0; k <= nwait; k++) begin
      @(posedge clk); #1;
      chk("req_busy", 64'(dmem_req), 64'd1);
      chk("we_busy", 64'(dmem_we), 64'(wr));
      chk("addr", dmem_addr, {a[63:3], 3'b000});
      chk("wstrb", 64'(dmem_wstrb), 64'(strb));
      if (wr) chk("wdata", dmem_wdata & lm, ewd);
      chk("stall_busy", 64'(stall), 64'd1);
      dmem_ready = (k == nwait);
      dmem_rdata = rdat;
    end
    @(posedge clk); #1;
    chk("stall_done", 64'(stall), 64'd0);
    chk("req_done", 64'(dmem_req), 64'd0);
    chk("we_done", 64'(dmem_we), 64'd0);
    chk("wb_done", wb_data, rd ? ref_load(rdat, a, f3) : a);
    dmem_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] a;
    int kind;
    rst = 1'b1;
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b011; alu_fpu_result = 64'h1000;
    write_data = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_we", 64'(dmem_we), 64'd0);
    chk("rst_addr", dmem_addr, 64'd0);
    chk("rst_wdata", dmem_wdata, 64'd0);
    chk("rst_wstrb", 64'(dmem_wstrb), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run(1, 0, 3'b010, 64'h1004, 64'h0,
        64'h8000_0000_0000_0000, 0);
    run(1, 0, 3'b100, 64'h1003, 64'h0,
        64'h0000_0000_AB00_0000, 0);
    run(0, 1, 3'b001, 64'h2006, 64'h1234, 64'h0, 4);
    run(1, 0, 3'b010, 64'h1002, 64'h0, 64'h0, 0);
    run(0, 0, 3'b000, 64'h55, 64'h0, 64'h0, 0);
    run(1, 0, 3'b000, 64'h4007, 64'h0,
        64'h8100_0000_0000_0000, 1);
    run(1, 0, 3'b011, 64'h4008, 64'h0,
        64'hDEAD_BEEF_0123_4567, 2);

    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b011; alu_fpu_result = 64'h3000; dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_req_before", 64'(dmem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_req", 64'(dmem_req), 64'd0);
    chk("rstmid_stall", 64'(stall), 64'd0);
    valid_in = 1'b0; alu_fpu_result = 64'h77;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid_idle_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    chk("rstmid_no_wb", wb_data, 64'h77);
    chk("rstmid_no_req", 64'(dmem_req), 64'd0);
    run(1, 0, 3'b001, 64'h3002, 64'h0,
        64'h0000_0000_F00D_0000, 0);

    for (int t = 0; t < 200; t++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      kind = int'($urandom_range(0, 2));
      run(kind == 0, kind == 1, 3'($urandom_range(0, 7)), a,
          {$urandom, $urandom}, {$urandom, $urandom},
          int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
